// File: rtl/cim_pkg.sv
// Shared definitions for the CIM bit-serial activation driver.
//   N_CH   : number of lanes feeding the adder tree
//   ACT_W  : activation width, also the number of planes per frame
//   W_W    : weight width, also the partial-product lane width
//   State encoding for the driver FSM and a lane-slicing helper for the packed activation bus.
package cim_pkg;

    localparam int unsigned N_CH   = 32;
    localparam int unsigned ACT_W  = 4;
    localparam int unsigned W_W    = 4;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned BIT_W  = 2;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SHIFT = 1'b1;

    // Lane i of the packed activation bus sits at bits [i*ACT_W +: ACT_W].
    function automatic logic [ACT_W-1:0] act_lane(input logic [N_CH*ACT_W-1:0] bus,
                                                  input int unsigned lane);
        return bus[lane*ACT_W +: ACT_W];
    endfunction

endpackage

// File: rtl/cim_plane_gate.sv
// Combinational partial-product plane generator.
//   act_bit_i : one activation bit per lane (the bit of the plane being emitted)
//   weight_i  : per-lane weights
//   pp_o      : packed plane, lane i = act_bit_i[i] ? weight_i[i] : 0 (plain AND, no carries)
module cim_plane_gate
    import cim_pkg::*;
(
    input  logic [N_CH-1:0]     act_bit_i,
    input  logic [W_W-1:0]      weight_i [N_CH],
    output logic [N_CH*W_W-1:0] pp_o
);

    always_comb begin
        pp_o = '0;
        for (int i = 0; i < N_CH; i++) begin
            pp_o[i*W_W +: W_W] = weight_i[i] & {W_W{act_bit_i[i]}};
        end
    end

endmodule

// File: rtl/cim_bitserial_driver.sv
// Bit-serial activation driver for the CIM macro array.
// Accepts a 32-lane vector of 4-bit activations per frame (valid/ready), holds a 32-entry
// weight register file, and emits one registered partial-product plane per cycle, MSB first.
//   clk, rst_n       : clock, asynchronous active-low reset
//   w_we_i/w_addr_i/w_data_i : weight write port (IDLE only), w_drop_o pulses on a dropped write
//   act_valid_i/act_ready_o/act_data_i : activation vector handshake
//   pp_valid_o/pp_data_o/pp_bit_o/pp_first_o/pp_last_o : plane stream to the adder tree
//   busy_o           : frame in progress
module cim_bitserial_driver
    import cim_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    w_we_i,
    input  logic [ADDR_W-1:0]       w_addr_i,
    input  logic [W_W-1:0]          w_data_i,
    output logic                    w_drop_o,
    input  logic                    act_valid_i,
    output logic                    act_ready_o,
    input  logic [N_CH*ACT_W-1:0]   act_data_i,
    output logic                    pp_valid_o,
    output logic [N_CH*W_W-1:0]     pp_data_o,
    output logic [BIT_W-1:0]        pp_bit_o,
    output logic                    pp_first_o,
    output logic                    pp_last_o,
    output logic                    busy_o
);

    state_t                 state_q, state_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [N_CH*ACT_W-1:0]  act_q, act_d;
    logic [W_W-1:0]         weight_q [N_CH];

    logic                   pp_valid_q, pp_valid_d;
    logic [N_CH*W_W-1:0]    pp_data_q, pp_data_d;
    logic [BIT_W-1:0]       pp_bit_q, pp_bit_d;
    logic                   pp_first_q, pp_first_d;
    logic                   pp_last_q, pp_last_d;
    logic                   w_drop_q, w_drop_d;

    logic                   act_ready;
    logic                   act_hs;
    logic                   addr_ok;
    logic                   w_wr;
    logic [N_CH-1:0]        act_bit;
    logic [N_CH*W_W-1:0]    plane;

    // Ready never looks at act_valid_i, so the source sees a stable ready in every cycle.
    assign act_ready = (state_q == ST_IDLE) || (state_q == ST_SHIFT && bit_cnt_q == '0);
    assign act_hs    = act_valid_i && act_ready;

    // With a full address space every index is a real lane; only check when lanes are fewer.
    if (N_CH < (1 << ADDR_W)) begin : g_addr_chk
        assign addr_ok = (32'(w_addr_i) < N_CH);
    end else begin : g_addr_full
        assign addr_ok = 1'b1;
    end

    // Writes only land while no frame is using the weights; a same-cycle handshake wins.
    assign w_wr     = w_we_i && addr_ok && (state_q == ST_IDLE) && !act_hs;
    assign w_drop_d = w_we_i && addr_ok && ((state_q == ST_SHIFT) || act_hs);

    always_comb begin
        logic [ACT_W-1:0] lane;
        lane    = '0;
        act_bit = '0;
        for (int i = 0; i < N_CH; i++) begin
            lane       = act_lane(act_q, i);
            act_bit[i] = lane[bit_cnt_q];
        end
    end

    cim_plane_gate u_plane_gate (
        .act_bit_i (act_bit),
        .weight_i  (weight_q),
        .pp_o      (plane)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        act_d      = act_q;
        pp_valid_d = 1'b0;
        pp_data_d  = pp_data_q;
        pp_bit_d   = pp_bit_q;
        pp_first_d = pp_first_q;
        pp_last_d  = pp_last_q;
        case (state_q)
            ST_IDLE: begin
                if (act_hs) begin
                    act_d     = act_data_i;
                    bit_cnt_d = BIT_W'(ACT_W - 1);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                pp_valid_d = 1'b1;
                pp_data_d  = plane;
                pp_bit_d   = bit_cnt_q;
                pp_first_d = (bit_cnt_q == BIT_W'(ACT_W - 1));
                pp_last_d  = (bit_cnt_q == '0);
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end else if (act_valid_i) begin
                    // Reload on the last plane so the next frame follows with no bubble.
                    act_d     = act_data_i;
                    bit_cnt_d = BIT_W'(ACT_W - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            act_q      <= '0;
            pp_valid_q <= 1'b0;
            pp_data_q  <= '0;
            pp_bit_q   <= '0;
            pp_first_q <= 1'b0;
            pp_last_q  <= 1'b0;
            w_drop_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            act_q      <= act_d;
            pp_valid_q <= pp_valid_d;
            pp_data_q  <= pp_data_d;
            pp_bit_q   <= pp_bit_d;
            pp_first_q <= pp_first_d;
            pp_last_q  <= pp_last_d;
            w_drop_q   <= w_drop_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                weight_q[i] <= '0;
            end
        end else if (w_wr) begin
            weight_q[w_addr_i] <= w_data_i;
        end
    end

    assign act_ready_o = act_ready;
    assign w_drop_o    = w_drop_q;
    assign pp_valid_o  = pp_valid_q;
    assign pp_data_o   = pp_data_q;
    assign pp_bit_o    = pp_bit_q;
    assign pp_first_o  = pp_first_q;
    assign pp_last_o   = pp_last_q;
    assign busy_o      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_cim_bitserial_driver.sv
// Self-checking bench for cim_bitserial_driver: directed scenarios plus a randomized run,
// all checked against a queue-of-planes reference model built from the plane/weight rules.
module tb_cim_bitserial_driver;
    import cim_pkg::*;

    logic                   clk;
    logic                   rst_n;
    logic                   w_we;
    logic [ADDR_W-1:0]      w_addr;
    logic [W_W-1:0]         w_data;
    logic                   w_drop;
    logic                   act_valid;
    logic                   act_ready;
    logic [N_CH*ACT_W-1:0]  act_data;
    logic                   pp_valid;
    logic [N_CH*W_W-1:0]    pp_data;
    logic [1:0]             pp_bit;
    logic                   pp_first;
    logic                   pp_last;
    logic                   busy;

    cim_bitserial_driver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .w_we_i      (w_we),
        .w_addr_i    (w_addr),
        .w_data_i    (w_data),
        .w_drop_o    (w_drop),
        .act_valid_i (act_valid),
        .act_ready_o (act_ready),
        .act_data_i  (act_data),
        .pp_valid_o  (pp_valid),
        .pp_data_o   (pp_data),
        .pp_bit_o    (pp_bit),
        .pp_first_o  (pp_first),
        .pp_last_o   (pp_last),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N_CH*W_W-1:0] data;
        logic [1:0]          b;
    } plane_t;

    // Reference model: weights, planes still owed to the consumer, expected dot products.
    plane_t              pend[$];
    int                  dot_q[$];
    logic [W_W-1:0]      wm [N_CH];
    logic                exp_valid;
    logic [N_CH*W_W-1:0] exp_data;
    logic [1:0]          exp_bit;
    logic                exp_first;
    logic                exp_last;
    logic                exp_drop;
    int                  n_hs;

    int checks;
    int failures;

    function automatic int plane_sum(input logic [N_CH*W_W-1:0] d);
        int s = 0;
        for (int i = 0; i < N_CH; i++) s += int'(d[i*W_W +: W_W]);
        return s;
    endfunction

    task automatic model_reset();
        pend.delete();
        dot_q.delete();
        for (int i = 0; i < N_CH; i++) wm[i] = '0;
        exp_valid = 1'b0;
        exp_drop  = 1'b0;
    endtask

    // One clock: the model decides the handshake from how many planes are still owed
    // (ready when at most the final plane remains), then returns at posedge+1.
    task automatic tick();
        logic                  hs;
        logic                  busy_m;
        logic                  we;
        logic [ADDR_W-1:0]     addr;
        logic [W_W-1:0]        wd;
        logic [N_CH*ACT_W-1:0] a;
        plane_t                p;
        int                    dot;
        hs     = act_valid && (pend.size() <= 1);
        busy_m = pend.size() > 0;
        we     = w_we;
        addr   = w_addr;
        wd     = w_data;
        a      = act_data;
        @(posedge clk);
        #1;
        if (pend.size() > 0) begin
            p         = pend.pop_front();
            exp_valid = 1'b1;
            exp_data  = p.data;
            exp_bit   = p.b;
            exp_first = (p.b == 2'd3);
            exp_last  = (p.b == 2'd0);
        end else begin
            exp_valid = 1'b0;
        end
        exp_drop = we && (busy_m || hs);
        if (we && !busy_m && !hs) wm[addr] = wd;
        if (hs) begin
            n_hs++;
            dot = 0;
            for (int i = 0; i < N_CH; i++) dot += int'(wm[i]) * int'(a[i*ACT_W +: ACT_W]);
            dot_q.push_back(dot);
            for (int b = ACT_W - 1; b >= 0; b--) begin
                p.b    = 2'(b);
                p.data = '0;
                for (int i = 0; i < N_CH; i++) begin
                    if (a[i*ACT_W + b]) p.data[i*W_W +: W_W] = wm[i];
                end
                pend.push_back(p);
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        w_we      = 1'b0;
        w_addr    = '0;
        w_data    = '0;
        act_valid = 1'b0;
        act_data  = '0;
        n_hs      = 0;
        model_reset();
        #12;
        checks++;
        if ({pp_valid, pp_bit, pp_first, pp_last, w_drop, busy} !== 6'b0 || pp_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b bit=%0d first=%b last=%b drop=%b busy=%b data=%h want all 0",
                     pp_valid, pp_bit, pp_first, pp_last, w_drop, busy, pp_data);
        end
        checks++;
        if (act_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got %b want 1", act_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (pp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_valid got %b want 0", pp_valid);
        end
    endtask

    task automatic test_pattern();
        int sum;
        logic [N_CH*W_W-1:0] want;
        for (int i = 0; i < N_CH; i++) begin
            w_we   = 1'b1;
            w_addr = ADDR_W'(i);
            w_data = 4'hF;
            tick();
            checks++;
            if (w_drop !== 1'b0) begin
                failures++;
                $display("FAIL pattern_wdrop lane=%0d got %b want 0", i, w_drop);
            end
        end
        w_we = 1'b0;
        for (int i = 0; i < N_CH; i++) act_data[i*ACT_W +: ACT_W] = 4'b1010;
        act_valid = 1'b1;
        tick();
        act_valid = 1'b0;
        sum = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            want = (k % 2 == 0) ? {N_CH*W_W{1'b1}} : '0;
            checks++;
            if (pp_valid !== 1'b1 || pp_data !== want || pp_bit !== 2'(3 - k)
                || pp_first !== (k == 0) || pp_last !== (k == 3)) begin
                failures++;
                $display("FAIL pattern_plane%0d got v=%b bit=%0d f=%b l=%b data=%h want v=1 bit=%0d data=%h",
                         k, pp_valid, pp_bit, pp_first, pp_last, pp_data, 3 - k, want);
            end
            sum += plane_sum(pp_data) << pp_bit;
        end
        checks++;
        if (sum !== 4800) begin
            failures++;
            $display("FAIL pattern_sum got %0d want 4800", sum);
        end
        void'(dot_q.pop_front());
        tick();
        checks++;
        if (pp_valid !== 1'b0) begin
            failures++;
            $display("FAIL pattern_idle_valid got %b want 0", pp_valid);
        end
    endtask

    task automatic test_back_to_back();
        int start, nvalid, first_c, last_c;
        for (int i = 0; i < N_CH; i++) begin
            w_we   = 1'b1;
            w_addr = ADDR_W'(i);
            w_data = W_W'(i % 16);
            tick();
        end
        w_we = 1'b0;
        for (int i = 0; i < N_CH; i++) act_data[i*ACT_W +: ACT_W] = 4'hF;
        act_valid = 1'b1;
        start   = n_hs;
        nvalid  = 0;
        first_c = -1;
        last_c  = -1;
        for (int c = 0; c < 12; c++) begin
            if (n_hs >= start + 2) act_valid = 1'b0;
            checks++;
            if (act_ready !== (pend.size() <= 1)) begin
                failures++;
                $display("FAIL b2b_ready cyc=%0d got %b want %b", c, act_ready, pend.size() <= 1);
            end
            tick();
            checks++;
            if (pp_valid !== exp_valid || (exp_valid && (pp_data !== exp_data || pp_bit !== exp_bit
                || pp_first !== exp_first || pp_last !== exp_last))) begin
                failures++;
                $display("FAIL b2b_plane cyc=%0d got v=%b bit=%0d data=%h want v=%b bit=%0d data=%h",
                         c, pp_valid, pp_bit, pp_data, exp_valid, exp_bit, exp_data);
            end
            if (pp_valid) begin
                nvalid++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
        end
        checks++;
        if (nvalid != 8 || last_c - first_c + 1 != 8) begin
            failures++;
            $display("FAIL b2b_contiguous got valid=%0d span=%0d want 8 and 8",
                     nvalid, last_c - first_c + 1);
        end
        dot_q.delete();
    endtask

    task automatic test_drop();
        int drops, firsts;
        for (int i = 0; i < N_CH; i++) act_data[i*ACT_W +: ACT_W] = 4'hF;
        act_valid = 1'b1;
        drops  = 0;
        firsts = 0;
        for (int c = 0; c < 12; c++) begin
            w_we   = (c == 2);
            w_addr = 5'd5;
            w_data = 4'd7;
            if (n_hs >= 2 && c > 4) act_valid = 1'b0;
            tick();
            checks++;
            if (w_drop !== exp_drop) begin
                failures++;
                $display("FAIL drop_pulse cyc=%0d got %b want %b", c, w_drop, exp_drop);
            end
            if (w_drop === 1'b1) drops++;
            checks++;
            if (pp_valid !== exp_valid || (exp_valid && (pp_data !== exp_data || pp_bit !== exp_bit))) begin
                failures++;
                $display("FAIL drop_plane cyc=%0d got v=%b data=%h want v=%b data=%h",
                         c, pp_valid, pp_data, exp_valid, exp_data);
            end
            if (pp_valid && pp_first) begin
                firsts++;
                checks++;
                if (pp_data[5*W_W +: W_W] !== 4'd5) begin
                    failures++;
                    $display("FAIL drop_lane5 frame=%0d got %0d want 5", firsts, pp_data[5*W_W +: W_W]);
                end
            end
        end
        w_we = 1'b0;
        checks++;
        if (drops != 1) begin
            failures++;
            $display("FAIL drop_count got %0d want 1", drops);
        end
        dot_q.delete();
    endtask

    task automatic test_hold_valid();
        int firsts;
        int start;
        act_valid = 1'b1;
        firsts = 0;
        start  = n_hs;
        for (int c = 0; c < 17; c++) begin
            if (c == 12) act_valid = 1'b0;
            for (int i = 0; i < 4; i++) act_data[i*32 +: 32] = $urandom();
            tick();
            checks++;
            if (pp_valid !== exp_valid || (exp_valid && (pp_data !== exp_data || pp_bit !== exp_bit
                || pp_first !== exp_first || pp_last !== exp_last))) begin
                failures++;
                $display("FAIL hold_plane cyc=%0d got v=%b bit=%0d data=%h want v=%b bit=%0d data=%h",
                         c, pp_valid, pp_bit, pp_data, exp_valid, exp_bit, exp_data);
            end
            if (c < 12 && pp_valid && pp_first) firsts++;
        end
        checks++;
        if (firsts != 3 || n_hs - start != 3) begin
            failures++;
            $display("FAIL hold_handshakes got firsts=%0d hs=%0d want 3", firsts, n_hs - start);
        end
        dot_q.delete();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < N_CH; i++) begin
            w_we   = 1'b1;
            w_addr = ADDR_W'(i);
            w_data = 4'h9;
            tick();
        end
        w_we = 1'b0;
        for (int i = 0; i < N_CH; i++) act_data[i*ACT_W +: ACT_W] = 4'hF;
        act_valid = 1'b1;
        tick();
        act_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (pp_valid !== 1'b1 || pp_bit !== 2'd2) begin
            failures++;
            $display("FAIL rstmid_pre got v=%b bit=%0d want v=1 bit=2", pp_valid, pp_bit);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({pp_valid, pp_bit, pp_first, pp_last, w_drop, busy} !== 6'b0 || pp_data !== '0
            || act_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_outputs got v=%b bit=%0d f=%b l=%b drop=%b busy=%b rdy=%b data=%h want 0s rdy=1",
                     pp_valid, pp_bit, pp_first, pp_last, w_drop, busy, act_ready, pp_data);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        act_valid = 1'b1;
        tick();
        act_valid = 1'b0;
        checks++;
        if (pp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_release_valid got %b want 0", pp_valid);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (pp_valid !== 1'b1 || pp_bit !== 2'(3 - k) || pp_first !== (k == 0) || pp_data !== '0) begin
                failures++;
                $display("FAIL rstmid_plane%0d got v=%b bit=%0d f=%b data=%h want v=1 bit=%0d data=0",
                         k, pp_valid, pp_bit, pp_first, pp_data, 3 - k);
            end
        end
        tick();
        dot_q.delete();
    endtask

    task automatic test_random();
        int done, target, acc, want, cyc;
        done   = 0;
        target = n_hs + 200;
        acc    = 0;
        cyc    = 0;
        while (done < 200 && cyc < 20000) begin
            act_valid = (n_hs < target) && ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) act_data[i*32 +: 32] = $urandom();
            w_we   = ($urandom_range(0, 3) == 0);
            w_addr = ADDR_W'($urandom_range(0, N_CH - 1));
            w_data = W_W'($urandom());
            checks++;
            if (act_ready !== (pend.size() <= 1)) begin
                failures++;
                $display("FAIL rand_ready cyc=%0d got %b want %b", cyc, act_ready, pend.size() <= 1);
            end
            tick();
            cyc++;
            checks++;
            if (pp_valid !== exp_valid || (exp_valid && (pp_data !== exp_data || pp_bit !== exp_bit
                || pp_first !== exp_first || pp_last !== exp_last))) begin
                failures++;
                $display("FAIL rand_plane cyc=%0d got v=%b bit=%0d f=%b l=%b data=%h want v=%b bit=%0d data=%h",
                         cyc, pp_valid, pp_bit, pp_first, pp_last, pp_data, exp_valid, exp_bit, exp_data);
            end
            checks++;
            if (w_drop !== exp_drop) begin
                failures++;
                $display("FAIL rand_wdrop cyc=%0d got %b want %b", cyc, w_drop, exp_drop);
            end
            if (pp_valid) begin
                if (pp_first) acc = 0;
                acc += plane_sum(pp_data) << pp_bit;
                if (pp_last) begin
                    want = (dot_q.size() > 0) ? dot_q.pop_front() : -1;
                    checks++;
                    if (acc !== want) begin
                        failures++;
                        $display("FAIL rand_dot frame=%0d got %0d want %0d", done, acc, want);
                    end
                    done++;
                end
            end
        end
        w_we      = 1'b0;
        act_valid = 1'b0;
        checks++;
        if (done != 200) begin
            failures++;
            $display("FAIL rand_timeout got frames=%0d want 200", done);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_pattern();
        test_back_to_back();
        test_drop();
        test_hold_valid();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
